// File: rtl/udp_send_arbiter.sv
// Round-robin, frame-at-a-time arbiter sharing the core's single UDP transmit
// channel among NUM_REQ requesters, with length, timeout and link-loss guards.
module udp_send_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int MAX_LEN     = 1460,
  parameter int TIMEOUT_CYC = 65535,
  parameter int GAP_CYC     = 8
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   enet_phy_link,
  input  logic [NUM_REQ-1:0]     req_apply,
  input  logic [32*NUM_REQ-1:0]  req_data,
  input  logic [16*NUM_REQ-1:0]  req_len,
  input  logic [16*NUM_REQ-1:0]  req_src_port,
  input  logic [16*NUM_REQ-1:0]  req_dst_port,
  output logic [NUM_REQ-1:0]     req_data_en,
  output logic [NUM_REQ-1:0]     req_over,
  output logic [NUM_REQ-1:0]     req_err,
  output logic                   udp_send_apply,
  output logic [31:0]            udp_send_data,
  input  logic                   udp_send_data_en,
  output logic [15:0]            udp_send_data_len,
  input  logic                   udp_send_over,
  output logic [15:0]            udp_send_src_port,
  output logic [15:0]            udp_send_dst_port,
  output logic                   busy,
  output logic [2:0]             grant_id
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int GW = $clog2(GAP_CYC + 1);

  typedef enum logic [2:0] {IDLE, CHECK, APPLY, XFER, GAP} state_t;

  state_t              state;
  logic [10:0]         exp_words, word_cnt, word_inc, cnt_now;
  logic [TW-1:0]       timer;
  logic [GW-1:0]       gap_cnt;
  logic                any_req, xfer_act;
  logic [2:0]          nxt_id;
  logic [NUM_REQ-1:0]  g_oh;
  logic [31:0]         sel_data;
  logic [15:0]         nxt_len, nxt_src, nxt_dst;

  // grant_id doubles as last_grant; descending scan leaves the nearest
  // requester after it as the winner.
  always_comb begin
    any_req = 1'b0;
    nxt_id  = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      int idx;
      idx = (int'(grant_id) + k) % NUM_REQ;
      if (req_apply[idx]) begin
        any_req = 1'b1;
        nxt_id  = 3'(idx);
      end
    end
  end

  always_comb begin
    sel_data = '0;
    nxt_len  = '0;
    nxt_src  = '0;
    nxt_dst  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == 3'(i)) sel_data = req_data[32*i +: 32];
      if (nxt_id == 3'(i)) begin
        nxt_len = req_len[16*i +: 16];
        nxt_src = req_src_port[16*i +: 16];
        nxt_dst = req_dst_port[16*i +: 16];
      end
    end
  end

  assign xfer_act      = (state == APPLY) || (state == XFER);
  assign udp_send_data = xfer_act ? sel_data : '0;
  assign busy          = (state != IDLE);
  assign word_inc      = (word_cnt == 11'd2047) ? word_cnt : word_cnt + 11'd1;
  assign cnt_now       = udp_send_data_en ? word_inc : word_cnt;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign g_oh[i]        = (grant_id == 3'(i));
    assign req_data_en[i] = xfer_act && udp_send_data_en && g_oh[i];
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state             <= IDLE;
      grant_id          <= 3'(NUM_REQ - 1);
      udp_send_data_len <= '0;
      udp_send_src_port <= '0;
      udp_send_dst_port <= '0;
      udp_send_apply    <= 1'b0;
      req_over          <= '0;
      req_err           <= '0;
      exp_words         <= '0;
      word_cnt          <= '0;
      timer             <= '0;
      gap_cnt           <= '0;
    end else begin
      req_over <= '0;
      req_err  <= '0;
      case (state)
        IDLE: if (enet_phy_link && any_req) begin
          grant_id          <= nxt_id;
          udp_send_data_len <= nxt_len;
          udp_send_src_port <= nxt_src;
          udp_send_dst_port <= nxt_dst;
          state             <= CHECK;
        end
        CHECK: begin
          if (!enet_phy_link || udp_send_data_len == 16'd0 ||
              udp_send_data_len > 16'(MAX_LEN)) begin
            req_err <= g_oh;
            gap_cnt <= '0;
            state   <= GAP;
          end else begin
            exp_words      <= 11'((17'(udp_send_data_len) + 17'd3) >> 2);
            word_cnt       <= '0;
            timer          <= '0;
            udp_send_apply <= 1'b1;
            state          <= APPLY;
          end
        end
        APPLY, XFER: begin
          // Link loss outranks timeout, which outranks completion.
          if (!enet_phy_link || timer == TW'(TIMEOUT_CYC - 1)) begin
            req_err        <= g_oh;
            udp_send_apply <= 1'b0;
            gap_cnt        <= '0;
            state          <= GAP;
          end else if (state == XFER && udp_send_over) begin
            if (cnt_now == exp_words) req_over <= g_oh;
            else                      req_err  <= g_oh;
            gap_cnt <= '0;
            state   <= GAP;
          end else begin
            timer <= timer + TW'(1);
            if (udp_send_data_en) begin
              word_cnt <= word_inc;
              if (state == APPLY) begin
                udp_send_apply <= 1'b0;
                state          <= XFER;
              end
            end
          end
        end
        GAP: begin
          if (gap_cnt == GW'(GAP_CYC - 1)) state <= IDLE;
          else                             gap_cnt <= gap_cnt + GW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_udp_send_arbiter.sv
// Scoreboarded bench for udp_send_arbiter: a simple core model serves frames,
// expected over/err outcomes are queued up front and matched on each pulse.
module tb_udp_send_arbiter;
  localparam int NR  = 4;
  localparam int GAP = 8;
  localparam int TMO = 100;

  logic            Clk = 1'b0;
  logic            Rst = 1'b1;
  logic            enet_phy_link = 1'b1;
  logic [NR-1:0]   req_apply = '0;
  logic [32*NR-1:0] req_data;
  logic [16*NR-1:0] req_len, req_src_port, req_dst_port;
  logic [NR-1:0]   req_data_en, req_over, req_err;
  logic            udp_send_apply, udp_send_data_en = 1'b0, udp_send_over = 1'b0;
  logic [31:0]     udp_send_data;
  logic [15:0]     udp_send_data_len, udp_send_src_port, udp_send_dst_port;
  logic            busy;
  logic [2:0]      grant_id;

  logic [15:0]     len_a   [NR];
  logic [23:0]     data_cnt[NR];

  typedef struct packed { logic [2:0] id; logic err; } exp_t;
  exp_t sb[$];
  int n_tests = 0, n_fail = 0;

  udp_send_arbiter #(.NUM_REQ(NR), .MAX_LEN(1460), .TIMEOUT_CYC(TMO), .GAP_CYC(GAP)) dut (
    .Clk(Clk), .Rst(Rst), .enet_phy_link(enet_phy_link),
    .req_apply(req_apply), .req_data(req_data), .req_len(req_len),
    .req_src_port(req_src_port), .req_dst_port(req_dst_port),
    .req_data_en(req_data_en), .req_over(req_over), .req_err(req_err),
    .udp_send_apply(udp_send_apply), .udp_send_data(udp_send_data),
    .udp_send_data_en(udp_send_data_en), .udp_send_data_len(udp_send_data_len),
    .udp_send_over(udp_send_over), .udp_send_src_port(udp_send_src_port),
    .udp_send_dst_port(udp_send_dst_port), .busy(busy), .grant_id(grant_id)
  );

  always #5 Clk = ~Clk;

  always_comb begin
    for (int i = 0; i < NR; i++) begin
      req_data[32*i +: 32]     = {8'(i), data_cnt[i]};
      req_len[16*i +: 16]      = len_a[i];
      req_src_port[16*i +: 16] = 16'h1000 + 16'(i);
      req_dst_port[16*i +: 16] = 16'h2000 + 16'(i);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk); #1;
  endtask

  // Scoreboard: every over/err pulse must match the next queued outcome.
  initial forever begin
    @(negedge Clk);
    if ((|req_over) || (|req_err)) begin
      int gid;
      exp_t e;
      gid = 0;
      for (int i = 0; i < NR; i++) if (req_over[i] || req_err[i]) gid = i;
      chk("excl", 32'((|req_over) && (|req_err)), 0);
      chk("onehot", $countones(req_over | req_err), 1);
      if (sb.size() == 0) chk("unexpected_pulse", 32'(gid), 32'hdead);
      else begin
        e = sb.pop_front();
        chk("pulse_id", 32'(gid), 32'(e.id));
        chk("pulse_kind", 32'(|req_err), 32'(e.err));
      end
    end
  end

  task automatic serve(input int g, input int hold, input int nwords, input bit do_over,
                       input logic [15:0] exp_len, output int wait_cyc);
    wait_cyc = 0;
    while (!udp_send_apply && wait_cyc < 200) begin tick(); wait_cyc++; end
    chk("apply_seen", 32'(udp_send_apply), 1);
    chk("grant_id", 32'(grant_id), 32'(g));
    chk("len", 32'(udp_send_data_len), 32'(exp_len));
    chk("src", 32'(udp_send_src_port), 32'h1000 + 32'(g));
    chk("dst", 32'(udp_send_dst_port), 32'h2000 + 32'(g));
    for (int h = 0; h < hold; h++) begin tick(); chk("apply_hold", 32'(udp_send_apply), 1); end
    for (int k = 0; k < nwords; k++) begin
      udp_send_data_en = 1'b1;
      #1;
      chk("data_en_steer", 32'(req_data_en), 32'(1 << g));
      chk("data", udp_send_data, {8'(g), data_cnt[g]});
      tick();
      data_cnt[g] = data_cnt[g] + 24'd1;
      if (k == 0) chk("apply_drop", 32'(udp_send_apply), 0);
    end
    udp_send_data_en = 1'b0;
    if (do_over) begin
      udp_send_over = 1'b1;
      tick();
      udp_send_over = 1'b0;
    end
  endtask

  task automatic wait_pulse(input int maxc, output int cyc, output bit saw_apply);
    cyc = 0;
    saw_apply = 1'b0;
    while (!((|req_over) || (|req_err)) && cyc < maxc) begin
      saw_apply |= udp_send_apply;
      tick();
      cyc++;
    end
    chk("pulse_wait", 32'(cyc < maxc), 1);
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while (busy && c < 50) begin tick(); c++; end
    chk("idle", 32'(busy), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wc, cyc;
    bit saw;
    for (int i = 0; i < NR; i++) begin len_a[i] = 16'd64; data_cnt[i] = 24'h100 * 24'(i); end
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_grant", 32'(grant_id), 3);
    chk("rst_apply", 32'(udp_send_apply), 0);
    chk("rst_pulses", 32'({req_over, req_err}), 0);
    chk("rst_len", 32'(udp_send_data_len), 0);
    Rst = 1'b0;
    tick();

    // Single requester 1, 10 bytes -> 3 words
    len_a[1] = 16'd10;
    sb.push_back('{id: 3'd1, err: 1'b0});
    req_apply[1] = 1'b1;
    serve(1, 3, 3, 1'b1, 16'd10, wc);
    req_apply[1] = 1'b0;
    wait_idle();
    len_a[1] = 16'd64;

    // Fairness from reset: all asserting
    Rst = 1'b1; tick(); Rst = 1'b0;
    for (int f = 0; f < 5; f++) sb.push_back('{id: 3'(f % NR), err: 1'b0});
    req_apply = '1;
    for (int f = 0; f < 5; f++) begin
      serve(f % NR, 0, 16, 1'b1, 16'd64, wc);
      if (f > 0) chk("gap_cycles", 32'(wc >= GAP), 1);
    end
    req_apply = '0;
    wait_idle();

    // Illegal lengths
    len_a[2] = 16'd0;
    sb.push_back('{id: 3'd2, err: 1'b1});
    req_apply[2] = 1'b1;
    wait_pulse(40, cyc, saw);
    chk("len0_no_apply", 32'(saw | udp_send_apply), 0);
    req_apply[2] = 1'b0;
    wait_idle();
    len_a[2] = 16'd64;
    len_a[3] = 16'd1461;
    sb.push_back('{id: 3'd3, err: 1'b1});
    req_apply[3] = 1'b1;
    wait_pulse(40, cyc, saw);
    chk("len1461_no_apply", 32'(saw | udp_send_apply), 0);
    chk("len1461_err", 32'(req_err), 32'b1000);
    req_apply[3] = 1'b0;
    wait_idle();
    len_a[3] = 16'd64;

    // Timeout on requester 0, then requester 1 served
    sb.push_back('{id: 3'd0, err: 1'b1});
    sb.push_back('{id: 3'd1, err: 1'b0});
    req_apply = 4'b0011;
    wc = 0;
    while (!udp_send_apply && wc < 50) begin tick(); wc++; end
    chk("tmo_grant", 32'(grant_id), 0);
    wait_pulse(300, cyc, saw);
    chk("tmo_cycles", 32'(cyc), TMO);
    chk("tmo_err", 32'(req_err), 32'b0001);
    chk("tmo_apply", 32'(udp_send_apply), 0);
    req_apply[0] = 1'b0;
    serve(1, 0, 16, 1'b1, 16'd64, wc);
    req_apply[1] = 1'b0;
    wait_idle();

    // Link loss after 5 of 16 words
    sb.push_back('{id: 3'd2, err: 1'b1});
    req_apply[2] = 1'b1;
    serve(2, 0, 5, 1'b0, 16'd64, wc);
    enet_phy_link = 1'b0;
    tick();
    chk("link_err", 32'(req_err), 32'b0100);
    chk("link_apply", 32'(udp_send_apply), 0);
    udp_send_data_en = 1'b1;
    #1;
    chk("gap_no_data_en", 32'(req_data_en), 0);
    chk("gap_data_zero", udp_send_data, 0);
    tick();
    udp_send_data_en = 1'b0;
    req_apply[2] = 1'b0;
    req_apply[3] = 1'b1;
    saw = 1'b0;
    for (int c = 0; c < 30; c++) begin saw |= udp_send_apply; tick(); end
    chk("linkdown_no_apply", 32'(saw), 0);
    chk("linkdown_idle", 32'(busy), 0);
    sb.push_back('{id: 3'd3, err: 1'b0});
    enet_phy_link = 1'b1;
    serve(3, 0, 16, 1'b1, 16'd64, wc);
    req_apply[3] = 1'b0;
    wait_idle();

    // Word-count mismatch: 16 bytes but 3 words
    len_a[0] = 16'd16;
    sb.push_back('{id: 3'd0, err: 1'b1});
    req_apply[0] = 1'b1;
    serve(0, 0, 3, 1'b1, 16'd16, wc);
    chk("mismatch_err", 32'(req_err), 32'b0001);
    req_apply[0] = 1'b0;
    wait_idle();
    len_a[0] = 16'd64;

    // Reset mid-XFER on requester 1, then requester 0 wins
    req_apply[1] = 1'b1;
    serve(1, 0, 2, 1'b0, 16'd64, wc);
    Rst = 1'b1;
    tick();
    chk("rstx_apply", 32'(udp_send_apply), 0);
    chk("rstx_busy", 32'(busy), 0);
    chk("rstx_grant", 32'(grant_id), 3);
    chk("rstx_len", 32'(udp_send_data_len), 0);
    chk("rstx_pulses", 32'({req_over, req_err}), 0);
    Rst = 1'b0;
    sb.push_back('{id: 3'd0, err: 1'b0});
    sb.push_back('{id: 3'd1, err: 1'b0});
    req_apply[0] = 1'b1;
    serve(0, 0, 16, 1'b1, 16'd64, wc);
    req_apply[0] = 1'b0;
    serve(1, 0, 16, 1'b1, 16'd64, wc);
    req_apply[1] = 1'b0;
    wait_idle();

    repeat (3) tick();
    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/udp_send_arbiter.md
Name: udp_send_arbiter

Overview:
- Shares the single-channel UDP transmit interface of the Ethernet core among NUM_REQ independent requesters, for example telemetry, reply and status sources.
- Round-robin arbitration runs one whole frame at a time. The granted requester's data, length and ports are latched or muxed onto the core's send interface.
- The core's read strobe and completion are steered back to the granted requester.
- Enforces length limits, a per-frame timeout and link-loss abort, so no requester can lock up the channel.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MAX_LEN, 1460, largest legal frame length in bytes.
- TIMEOUT_CYC, 65535, Clk cycles allowed from grant to udp_send_over.
- GAP_CYC, 8, idle Clk cycles enforced after each frame before the next grant.

Ports:
- Clk  in  1  user clock; all logic on its rising edge.
- Rst  in  1  synchronous reset, active high.
- enet_phy_link  in  1  link status from the core; 1 = link up.
- req_apply  in  NUM_REQ  per-requester send request; level, held until req_over or req_err.
- req_data  in  32*NUM_REQ  per-requester data word, FWFT FIFO output; requester i occupies bits [32i+31:32i].
- req_len  in  16*NUM_REQ  per-requester frame length in bytes.
- req_src_port  in  16*NUM_REQ  per-requester UDP source port.
- req_dst_port  in  16*NUM_REQ  per-requester UDP destination port.
- req_data_en  out  NUM_REQ  per-requester FIFO read strobe.
- req_over  out  NUM_REQ  one-cycle pulse: frame sent correctly.
- req_err  out  NUM_REQ  one-cycle pulse: frame rejected or aborted.
- udp_send_apply  out  1  request to the core.
- udp_send_data  out  32  data to the core.
- udp_send_data_en  in  1  core read strobe.
- udp_send_data_len  out  16  frame length to the core.
- udp_send_over  in  1  core frame-complete pulse.
- udp_send_src_port  out  16  source port to the core.
- udp_send_dst_port  out  16  destination port to the core.
- busy  out  1  high in every state except IDLE.
- grant_id  out  3  index of the current or last granted requester.

Behaviour:
- Reset values:
  - State = IDLE; last_grant = NUM_REQ-1, so requester 0 wins first.
  - All outputs are 0, except grant_id = NUM_REQ-1.
- States are IDLE, CHECK, APPLY, XFER, GAP.
- IDLE:
  - When enet_phy_link = 1 and any req_apply bit is high, select the first requester at or after last_grant+1 (mod NUM_REQ) with req_apply = 1.
  - Latch its index into grant_id and last_grant, and latch its req_len, req_src_port and req_dst_port into the udp_send_* output registers.
  - Go to CHECK.
  - When the link is down, no grant is issued.
- CHECK:
  - If the latched len = 0 or len > MAX_LEN, pulse req_err[g] and go to GAP.
  - Otherwise load exp_words = (len+3)>>2, clear word_cnt and timer, and go to APPLY.
- APPLY: udp_send_apply = 1, held until the first udp_send_data_en is seen; then go to XFER with udp_send_apply = 0 from the next cycle.
- Data path, which is combinational with zero latency in APPLY and XFER:
  - udp_send_data = req_data slice of requester g.
  - req_data_en[g] = udp_send_data_en; all other req_data_en bits are 0.
  - Outside APPLY and XFER, every req_data_en bit is 0 and udp_send_data = 0.
- Word counting: word_cnt increments on each udp_send_data_en and saturates at 2047.
- XFER, on udp_send_over = 1:
  - If word_cnt (including a data_en in the same cycle) = exp_words, pulse req_over[g].
  - Otherwise pulse req_err[g].
  - In both cases go to GAP.
- Timeout: timer counts every cycle in APPLY and XFER. When it reaches TIMEOUT_CYC, pulse req_err[g], drop udp_send_apply and go to GAP.
- Link loss: enet_phy_link = 0 in CHECK, APPLY or XFER aborts the frame with req_err[g], drops udp_send_apply and goes to GAP. This has priority over over/timeout in the same cycle.
- GAP:
  - Count GAP_CYC cycles, then go to IDLE.
  - req_apply bits are ignored during GAP; the requester must deassert within GAP_CYC cycles of its over/err pulse.
  - Any udp_send_data_en arriving in GAP is ignored and not forwarded.
- Exclusivity: req_over and req_err never pulse together, and at most one bit of each pulses per frame.
- Fairness: with all requesters continuously asserting, grants rotate 0, 1, 2, ... NUM_REQ-1, 0.
- A requester dropping req_apply mid-frame has no effect; the frame finishes or times out.
- Rst mid-frame: all outputs go to reset values on the next edge, with no over/err pulse.

Test Plan:
- Single requester 1, len = 10, core gives 3 data_en then over → udp_send_apply high until the first data_en; req_data_en[1] mirrors all 3 strobes; req_over[1] pulses once; grant_id = 1.
- All 4 requesters asserting continuously, len = 64 each → grant order 0, 1, 2, 3, 0; at least GAP_CYC idle cycles between consecutive udp_send_apply rises.
- req_len = 0 and, separately, req_len = 1461 → req_err pulse; udp_send_apply never asserted; arbiter returns to IDLE after GAP.
- Core never returns over (TIMEOUT_CYC = 100) → req_err at cycle 100 after APPLY entry; udp_send_apply low; the next requester is then served.
- enet_phy_link falls in XFER after 5 of 16 words → req_err immediately; no further req_data_en; no grant until the link returns to 1.
- len = 16 but core issues only 3 data_en before over → req_err (word mismatch); Rst asserted mid-XFER → all outputs 0 next cycle; the next grant goes to requester 0.
